// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: program-memory port, MEM-stage redirect and the IF/ID-facing queue head.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface fetch_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    logic [31:0]                  imem_addr;
    logic [31:0]                  imem_data;
    logic                         redirect;
    logic [31:0]                  redirect_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_instr;
    logic [31:0]                  out_pc4;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    logic                         misalign_err;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc4, occupancy, misalign_err,
        input  imem_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc4, occupancy, misalign_err,
        output imem_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches from combinational program memory and
// buffers {PC+4, instruction} pairs so ID stalls never drop a fetch; MEM redirects flush and restart.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               OCC_W    = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [31:0]      pc;
    logic [31:0]      pcNext;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [OCC_W-1:0] occ;
    logic             misalignErr;
    logic             outValid;
    logic             pop;
    logic             push;
    logic [63:0]      entries [DEPTH];
    logic [63:0]      headEntry;

    assign pcNext   = pc + 32'd4;
    assign outValid = (occ != '0);
    assign pop      = outValid & bus.out_ready & ~bus.redirect;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign push     = ~bus.redirect & ((occ != FULL_OCC) | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            rdPtr       <= '0;
            wrPtr       <= '0;
            occ         <= '0;
            misalignErr <= 1'b0;
        end else if (bus.redirect) begin
            pc    <= {bus.redirect_pc[31:2], 2'b00};
            rdPtr <= '0;
            wrPtr <= '0;
            occ   <= '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalignErr <= 1'b1;
            end
        end else begin
            if (push) begin
                pc    <= pcNext;
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Entry storage carries data only; validity is tracked by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wrPtr] <= {pcNext, bus.imem_data};
        end
    end

    assign headEntry        = entries[rdPtr];
    assign bus.imem_addr    = pc;
    assign bus.out_valid    = outValid;
    assign bus.out_instr    = outValid ? headEntry[31:0]  : 32'h0;
    assign bus.out_pc4      = outValid ? headEntry[63:32] : 32'h0;
    assign bus.occupancy    = occ;
    assign bus.misalign_err = misalignErr;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a queue-based reference model receives each expected fetch
// when the edge that pushes it is driven, and the head is compared whenever the DUT presents it.
module tb_fetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk;
    logic reset;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000_0000 + ((addr - RESET_PC) >> 2);
    endfunction

    assign bus.imem_data = memWord(bus.imem_addr);

    int          nChecks = 0;
    int          nFails  = 0;
    logic [63:0] sb[$];
    logic [31:0] modelPc;
    logic        modelMis;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply what the coming edge should do, using the inputs as currently driven.
    task automatic modelEdge();
        logic doPop;
        logic doPush;
        if (!reset) begin
            sb.delete();
            modelPc  = RESET_PC;
            modelMis = 1'b0;
        end else if (bus.redirect) begin
            sb.delete();
            modelPc = {bus.redirect_pc[31:2], 2'b00};
            if (bus.redirect_pc[1:0] != 2'b00) modelMis = 1'b1;
        end else begin
            doPop  = (sb.size() != 0) && bus.out_ready;
            doPush = (sb.size() < DEPTH) || doPop;
            if (doPop) void'(sb.pop_front());
            if (doPush) begin
                sb.push_back({modelPc + 32'd4, memWord(modelPc)});
                modelPc = modelPc + 32'd4;
            end
        end
    endtask

    task automatic checkOutputs();
        checkEq("imem_addr", bus.imem_addr, modelPc);
        checkEq("occupancy", 32'(bus.occupancy), 32'(sb.size()));
        checkEq("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        checkEq("misalign_err", 32'(bus.misalign_err), 32'(modelMis));
        if (sb.size() != 0) begin
            checkEq("head_pc4", bus.out_pc4, sb[0][63:32]);
            checkEq("head_instr", bus.out_instr, sb[0][31:0]);
        end else begin
            checkEq("idle_pc4", bus.out_pc4, 32'h0);
            checkEq("idle_instr", bus.out_instr, 32'h0);
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        modelPc         = 32'h0;
        modelMis        = 1'b0;
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b1;

        // Reset held for three clocks
        ticks(3);
        checkEq("rst_valid", 32'(bus.out_valid), 32'h0);
        checkEq("rst_instr", bus.out_instr, 32'h0);
        checkEq("rst_occ", 32'(bus.occupancy), 32'h0);
        checkEq("rst_addr", bus.imem_addr, 32'h0040_0000);

        // Streaming with the consumer always ready
        reset = 1'b1;
        tick();
        checkEq("stream_first_pc4", bus.out_pc4, 32'h0040_0004);
        checkEq("stream_first_instr", bus.out_instr, 32'h1000_0000);
        tick();
        checkEq("stream_second_pc4", bus.out_pc4, 32'h0040_0008);
        checkEq("stream_occ", 32'(bus.occupancy), 32'h1);
        ticks(8);

        // Stall from a fresh start until the queue saturates, then drain
        reset = 1'b0;
        tick();
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        ticks(6);
        checkEq("fill_occ", 32'(bus.occupancy), 32'h4);
        checkEq("fill_addr", bus.imem_addr, 32'h0040_0010);
        checkEq("fill_head_pc4", bus.out_pc4, 32'h0040_0004);
        bus.out_ready = 1'b1;
        ticks(6);

        // Refill, then redirect while full
        bus.out_ready = 1'b0;
        ticks(5);
        checkEq("full_occ", 32'(bus.occupancy), 32'h4);
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0020;
        tick();
        bus.redirect = 1'b0;
        checkEq("redir_valid", 32'(bus.out_valid), 32'h0);
        checkEq("redir_occ", 32'(bus.occupancy), 32'h0);
        tick();
        checkEq("redir_target_valid", 32'(bus.out_valid), 32'h1);
        checkEq("redir_target_pc4", bus.out_pc4, 32'h0040_0024);
        ticks(3);

        // Misaligned target: PC is aligned, sticky flag set
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0033;
        tick();
        bus.redirect = 1'b0;
        checkEq("mis_addr", bus.imem_addr, 32'h0040_0030);
        checkEq("mis_flag", 32'(bus.misalign_err), 32'h1);
        tick();
        checkEq("mis_target_pc4", bus.out_pc4, 32'h0040_0034);
        ticks(3);

        // Back-to-back redirects: the later target wins
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0100;
        tick();
        bus.redirect_pc = 32'h0040_0200;
        tick();
        bus.redirect = 1'b0;
        tick();
        checkEq("b2b_pc4", bus.out_pc4, 32'h0040_0204);
        checkEq("b2b_sticky", 32'(bus.misalign_err), 32'h1);

        // PC+4 wraps at the top of the address space
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        tick();
        checkEq("wrap_valid", 32'(bus.out_valid), 32'h1);
        checkEq("wrap_pc4", bus.out_pc4, 32'h0000_0000);
        checkEq("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Random stalls and occasional redirects
        for (int i = 0; i < 80; i++) begin
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = RESET_PC + 32'($urandom_range(0, 63)) * 32'd4;
            tick();
        end
        bus.redirect = 1'b0;

        // Reset mid-run overrides a simultaneous redirect
        reset = 1'b0;
        tick();
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        ticks(3);
        checkEq("mid_occ3", 32'(bus.occupancy), 32'h3);
        reset           = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0040_0083;
        tick();
        checkEq("mid_rst_addr", bus.imem_addr, RESET_PC);
        checkEq("mid_rst_occ", 32'(bus.occupancy), 32'h0);
        checkEq("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        checkEq("mid_rst_mis", 32'(bus.misalign_err), 32'h0);
        reset         = 1'b1;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
